// File: rtl/data_if_pkg.sv
// Shared definitions for the core data port: bus widths and the response record
// carried from the memory side back to the LSU.
package data_if_pkg;

  localparam int BE_W   = 4;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } data_resp_t;

endpackage

// File: rtl/resp_delay_line.sv
// Fixed-depth valid/payload shift register that carries responses from the
// acceptance edge to their presentation cycle, in order, with synchronous clear.
module resp_delay_line
  import data_if_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       in_valid,
  input  data_resp_t in_payload,
  output logic       out_valid,
  output data_resp_t out_payload
);

  logic       valid_reg   [LATENCY];
  data_resp_t payload_reg [LATENCY];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_reg[i]   <= 1'b0;
        payload_reg[i] <= '0;
      end
    end else begin
      valid_reg[0]   <= in_valid;
      payload_reg[0] <= in_payload;
      for (int i = 1; i < LATENCY; i++) begin
        valid_reg[i]   <= valid_reg[i-1];
        payload_reg[i] <= payload_reg[i-1];
      end
    end
  end

  assign out_valid   = valid_reg[LATENCY-1];
  assign out_payload = payload_reg[LATENCY-1];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port: req/gnt accept, word memory with
// byte-lane stores, address range check and a bounded count of in-flight responses.
module data_mem_responder
  import data_if_pkg::*;
#(
  parameter int          DEPTH_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter string       INIT_FILE       = ""
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [BE_W-1:0]   i_data_be,
  input  logic [31:0]       i_data_addr,
  input  logic [DATA_W-1:0] i_data_wdata,
  output logic              o_data_gnt,
  output logic              o_data_rvalid,
  output logic [DATA_W-1:0] o_data_rdata,
  output logic              o_data_err
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam int          CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] outstanding_next;
  logic          accept;
  logic          in_range;
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  data_resp_t    resp_in;
  data_resp_t    resp_out;
  logic          resp_valid;

  // gnt looks only at req and the registered count, never at addr or data.
  assign o_data_gnt = i_data_req && (outstanding_reg < CW'(MAX_OUTSTANDING));
  assign accept     = o_data_gnt && !i_rst;

  assign offset   = i_data_addr - BASE_ADDR;
  assign in_range = (i_data_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN)
                    && (i_data_addr[1:0] == 2'b00);
  assign word_idx = offset[AW+1:2];

  always_ff @(posedge i_clk) begin
    if (accept && i_data_we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_data_be[i]) mem[word_idx][i*8 +: 8] <= i_data_wdata[i*8 +: 8];
      end
    end
  end

  // Everything is forced to zero unless accepted, so idle X never reaches state.
  always_comb begin
    resp_in = '0;
    if (accept) begin
      resp_in.err = !in_range;
      if (in_range && !i_data_we) resp_in.rdata = mem[word_idx];
    end
  end

  resp_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .in_valid    (accept),
    .in_payload  (resp_in),
    .out_valid   (resp_valid),
    .out_payload (resp_out)
  );

  always_comb begin
    outstanding_next = outstanding_reg;
    if (accept && !resp_valid) outstanding_next = outstanding_reg + 1'b1;
    else if (!accept && resp_valid) outstanding_next = outstanding_reg - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) outstanding_reg <= '0;
    else       outstanding_reg <= outstanding_next;
  end

  assign o_data_rvalid = resp_valid;
  assign o_data_rdata  = resp_out.rdata;
  assign o_data_err    = resp_out.err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (latency 1 and latency 3) driven by
// directed and random requests and checked against a queue-based reference model.
module tb_data_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE1 = 32'h0000_0000;
  localparam logic [31:0] BASE3 = 32'h0000_2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, req1, we1, gnt1, rvalid1, err1;
  logic [3:0]  be1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        rst3, req3, we3, gnt3, rvalid3, err3;
  logic [3:0]  be3;
  logic [31:0] addr3, wdata3, rdata3;

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1), .LATENCY(1), .MAX_OUTSTANDING(2), .INIT_FILE("")
  ) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_data_req(req1), .i_data_we(we1), .i_data_be(be1),
    .i_data_addr(addr1), .i_data_wdata(wdata1), .o_data_gnt(gnt1), .o_data_rvalid(rvalid1),
    .o_data_rdata(rdata1), .o_data_err(err1)
  );

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE3), .LATENCY(3), .MAX_OUTSTANDING(2), .INIT_FILE("")
  ) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_data_req(req3), .i_data_we(we3), .i_data_be(be3),
    .i_data_addr(addr3), .i_data_wdata(wdata3), .o_data_gnt(gnt3), .o_data_rvalid(rvalid3),
    .o_data_rdata(rdata3), .o_data_err(err3)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl_mem [2][DEPTH];
  bit          sel;
  int          lat, maxo, cyc, total, bad, obs_rv_cnt;
  logic [31:0] base;
  logic        cur_rst, cur_req, cur_we;
  logic [3:0]  cur_be;
  logic [31:0] cur_addr, cur_wdata;
  bit          prev_rst, last_acc, last_gnt;

  logic        obs_gnt, obs_rv, obs_err;
  logic [31:0] obs_rdata;
  assign obs_gnt   = sel ? gnt3 : gnt1;
  assign obs_rv    = sel ? rvalid3 : rvalid1;
  assign obs_err   = sel ? err3 : err1;
  assign obs_rdata = sel ? rdata3 : rdata1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s (dut%0d cyc %0d): observed=%h expected=%h", tag, sel ? 3 : 1, cyc, obs, exp);
    end
  endtask

  task automatic use_dut(input bit s);
    sel  = s;
    lat  = s ? 3 : 1;
    maxo = 2;
    base = s ? BASE3 : BASE1;
    q.delete();
  endtask

  task automatic drive(input logic r, input logic rq, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    cur_rst = r; cur_req = rq; cur_we = w; cur_be = b; cur_addr = a; cur_wdata = d;
    if (sel) begin
      rst3 = r; req3 = rq; we3 = w; be3 = b; addr3 = a; wdata3 = d;
    end else begin
      rst1 = r; req1 = rq; we1 = w; be1 = b; addr1 = a; wdata1 = d;
    end
  endtask

  // One clock cycle: compare outputs mid-cycle against the model, then advance it.
  task automatic step();
    bit          e_gnt, e_rv, ok;
    int          w;
    exp_t        e;
    @(negedge clk);
    e_gnt = cur_req && (q.size() < maxo);
    chk("gnt", obs_gnt, e_gnt);
    e_rv = (q.size() > 0) && (q[0].due == cyc);
    chk("rvalid", obs_rv, e_rv);
    obs_rv_cnt += int'(obs_rv);
    if (e_rv) begin
      chk("rdata", obs_rdata, q[0].rdata);
      chk("err", obs_err, q[0].err);
      void'(q.pop_front());
    end
    if (prev_rst) begin
      chk("rst_rdata", obs_rdata, 32'h0);
      chk("rst_err", obs_err, 1'b0);
    end
    last_gnt = obs_gnt;
    last_acc = e_gnt && !cur_rst;
    if (last_acc) begin
      ok = (cur_addr >= base) && ((cur_addr - base) < 32'(4 * DEPTH)) && (cur_addr[1:0] == 2'b00);
      e.due   = cyc + lat;
      e.err   = !ok;
      e.rdata = 32'h0;
      if (ok) begin
        w = int'((cur_addr - base) / 4);
        if (cur_we) begin
          for (int i = 0; i < 4; i++)
            if (cur_be[i]) mdl_mem[sel][w][i*8 +: 8] = cur_wdata[i*8 +: 8];
        end else begin
          e.rdata = mdl_mem[sel][w];
        end
      end
      q.push_back(e);
    end
    if (cur_rst) q.delete();
    prev_rst = cur_rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    drive(1'b0, 1'b1, w, b, a, d);
    last_acc = 1'b0;
    while (!last_acc && n < 20) begin
      step();
      n++;
    end
    total++;
    assert (last_acc) else begin
      bad++;
      $error("FAIL issue_timeout addr=%h: observed=no_grant expected=grant", a);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(1'b0, 1'b0, 1'b0, 4'h0, $urandom, $urandom);
    while (q.size() > 0 && n < 20) begin
      step();
      n++;
    end
    step();
    chk("drain_pending", q.size(), 0);
  endtask

  function automatic logic [31:0] rand_addr(input logic [31:0] b);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7)       return b + 4 * $urandom_range(0, 15);
    else if (r == 7) return b + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
    else if (r == 8) return b + 32'(4 * DEPTH) + 4 * $urandom_range(0, 3);
    else             return b - 4 * $urandom_range(1, 4);
  endfunction

  task automatic random_phase(input int n);
    for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, base + 32'(4 * i), $urandom);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            rand_addr(base), $urandom);
      step();
    end
    drain();
  endtask

  initial begin
    logic [5:0] gpat;
    int         k;
    total = 0; bad = 0; cyc = 0; obs_rv_cnt = 0;
    rst1 = 1'b1; req1 = 1'b0; we1 = 1'b0; be1 = 4'h0; addr1 = 32'h0; wdata1 = 32'h0;
    rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; be3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
    use_dut(1'b0);

    // Reset held with req high: outputs stay zero, nothing is accepted.
    drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h10, 32'h0BAD_0BAD);
    @(posedge clk);
    #1;
    prev_rst = 1'b1;
    repeat (3) step();
    rst3 = 1'b0;

    // Store then load back-to-back, byte enables, errors.
    issue(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    issue(1'b1, 4'hF, 32'h20, 32'h1122_3344);
    issue(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
    issue(1'b0, 4'h0, 32'h20, 32'h0);
    issue(1'b1, 4'hF, 32'h0, 32'hCAFE_F00D);
    issue(1'b0, 4'h0, 32'h1002, 32'h0);
    issue(1'b1, 4'hF, BASE1 + 32'(4 * DEPTH), 32'hFFFF_FFFF);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    drain();
    chk("be_merge_model", mdl_mem[0][8], 32'h11BB_33DD);
    random_phase(200);

    use_dut(1'b1);
    random_phase(200);

    // Six loads with req held: gnt must follow 1,1,0,0,1,1.
    obs_rv_cnt = 0;
    gpat = '0;
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h0, BASE3 + 32'(4 * k), 32'h0);
      step();
      if (c < 6) gpat[5-c] = last_gnt;
      if (last_acc) k++;
    end
    drain();
    chk("bp_gnt_pattern", gpat, 6'b110011);
    chk("bp_accepts", k, 6);
    chk("bp_rvalid_count", obs_rv_cnt, 6);

    // Reset with two loads in flight: both responses are dropped.
    issue(1'b0, 4'h0, BASE3, 32'h0);
    issue(1'b0, 4'h0, BASE3 + 32'h4, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    obs_rv_cnt = 0;
    drive(1'b0, 1'b1, 1'b0, 4'h0, BASE3 + 32'h8, 32'h0);
    step();
    chk("post_rst_gnt", last_gnt, 1'b1);
    drain();
    chk("post_rst_rvalids", obs_rv_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
